// File: rtl/tetris_vga_capture.sv
// Rebuilds the two 10x20 Tetris grids from a VGA Hsync/Vsync/RGB stream and publishes them once per frame.
// Latency: 2 clk sync, frame_valid 2 clk after the 200th cell sample; frame_short 1 clk after synced Vsync fall.
// Backpressure: none; free-running capture, outputs hold between frame_valid pulses.
module tetris_vga_capture #(
    parameter int CLK_PER_PIXEL = 4,
    parameter int GRID_X0       = 257,
    parameter int GRID_Y0       = 80,
    parameter int CELL          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Hsync,
    input  logic         Vsync,
    input  logic [2:0]   R,
    input  logic [2:0]   G,
    input  logic [1:0]   B,
    output logic [199:0] GridA_out,
    output logic [199:0] GridB_out,
    output logic         frame_valid,
    output logic         decode_err,
    output logic         frame_short
);

    localparam int PH_W = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
    localparam logic [PH_W-1:0] PH_MAX  = PH_W'(CLK_PER_PIXEL - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLK_PER_PIXEL / 2);
    localparam logic [10:0]     X0      = 11'(GRID_X0);
    localparam logic [10:0]     Y0      = 11'(GRID_Y0);
    localparam logic [10:0]     X_SPAN  = 11'(10 * CELL);
    localparam logic [10:0]     Y_SPAN  = 11'(20 * CELL);
    localparam logic [10:0]     C_MASK  = 11'(CELL - 1);
    localparam logic [10:0]     C_HALF  = 11'(CELL / 2);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_FRAME   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic       hs_s1, hs_s2, hs_q;
    logic       vs_s1, vs_s2, vs_q;
    logic [7:0] rgb_d1, rgb_d2;
    logic       hs_rise, hs_fall, vs_fall;

    logic [8:0]       line_y;
    logic [9:0]       pix_x;
    logic [PH_W-1:0]  ph;
    logic [7:0]       cnt;
    logic             err_acc;
    logic [199:0]     shadow_a, shadow_b;

    logic [10:0] dx, dy;
    logic        x_hit, y_hit, strike;
    logic        dec_a, dec_b, dec_bad;
    logic        clr, shift, commit, short_nxt;

    // Syncs are idle-high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1  <= 1'b1;
            hs_s2  <= 1'b1;
            hs_q   <= 1'b1;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            vs_q   <= 1'b1;
            rgb_d1 <= 8'd0;
            rgb_d2 <= 8'd0;
        end else begin
            hs_s1  <= Hsync;
            hs_s2  <= hs_s1;
            hs_q   <= hs_s2;
            vs_s1  <= Vsync;
            vs_s2  <= vs_s1;
            vs_q   <= vs_s2;
            rgb_d1 <= {R, G, B};
            rgb_d2 <= rgb_d1;
        end
    end

    assign hs_rise = hs_s2 & ~hs_q;
    assign hs_fall = ~hs_s2 & hs_q;
    assign vs_fall = ~vs_s2 & vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_y <= 9'd0;
            pix_x  <= 10'd0;
            ph     <= '0;
        end else begin
            if (vs_fall) begin
                line_y <= 9'd0;
            end else if (hs_fall && line_y != 9'd511) begin
                line_y <= line_y + 9'd1;
            end
            if (hs_rise) begin
                ph    <= '0;
                pix_x <= 10'd0;
            end else if (ph == PH_MAX) begin
                ph <= '0;
                if (pix_x != 10'd1023) begin
                    pix_x <= pix_x + 10'd1;
                end
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    // Sign bit of the 11-bit difference marks positions left of / above the grid.
    assign dx     = {1'b0, pix_x} - X0;
    assign dy     = {2'b00, line_y} - Y0;
    assign x_hit  = !dx[10] && (dx < X_SPAN) && ((dx & C_MASK) == C_HALF);
    assign y_hit  = !dy[10] && (dy < Y_SPAN) && ((dy & C_MASK) == C_HALF);
    assign strike = (state == S_FRAME) && (ph == PH_MID) && x_hit && y_hit;

    always_comb begin
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_bad = 1'b0;
        if (rgb_d2[7:5] != 3'd0 && rgb_d2[4:2] == 3'd0 && rgb_d2[1:0] == 2'd0) begin
            dec_a = 1'b1;
        end else if (rgb_d2[7:5] == 3'd0 && rgb_d2[4:2] == 3'd0 && rgb_d2[1:0] != 2'd0) begin
            dec_b = 1'b1;
        end else if (rgb_d2[7:5] == 3'd0 && rgb_d2[4:2] != 3'd0 && rgb_d2[1:0] == 2'd0) begin
            dec_a = 1'b1;
            dec_b = 1'b1;
        end else if (rgb_d2 != 8'd0) begin
            dec_bad = 1'b1;
        end
    end

    // Vsync fall takes priority over a coincident strike.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift     = 1'b0;
        commit    = 1'b0;
        short_nxt = 1'b0;
        case (state)
            S_WAIT_VS: begin
                if (vs_fall) begin
                    clr       = 1'b1;
                    state_nxt = S_FRAME;
                end
            end
            S_FRAME: begin
                if (vs_fall) begin
                    clr       = 1'b1;
                    short_nxt = (cnt < 8'd200);
                end else if (strike) begin
                    shift = 1'b1;
                    if (cnt == 8'd199) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                commit    = 1'b1;
                state_nxt = S_WAIT_VS;
            end
            default: state_nxt = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_WAIT_VS;
            cnt         <= 8'd0;
            err_acc     <= 1'b0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            GridA_out   <= '0;
            GridB_out   <= '0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            frame_short <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_valid <= commit;
            frame_short <= short_nxt;
            if (clr) begin
                cnt     <= 8'd0;
                err_acc <= 1'b0;
            end else if (shift) begin
                cnt      <= cnt + 8'd1;
                err_acc  <= err_acc | dec_bad;
                shadow_a <= {shadow_a[198:0], dec_a};
                shadow_b <= {shadow_b[198:0], dec_b};
            end
            if (commit) begin
                GridA_out  <= shadow_a;
                GridB_out  <= shadow_b;
                decode_err <= err_acc;
            end
        end
    end

endmodule

// File: tb/tb_tetris_vga_capture.sv
// Directed bench: a compact VGA generator draws grids from a vector table and the decoded outputs are compared per frame.
module tb_tetris_vga_capture;

    localparam int CPP    = 4;
    localparam int X0     = 3;
    localparam int Y0     = 2;
    localparam int CELL   = 2;
    localparam int LPX    = 24;
    localparam int NLINES = 43;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Hsync, Vsync;
    logic [2:0]   R, G;
    logic [1:0]   B;
    logic [199:0] GridA_out, GridB_out;
    logic         frame_valid, decode_err, frame_short;

    tetris_vga_capture #(
        .CLK_PER_PIXEL(CPP),
        .GRID_X0      (X0),
        .GRID_Y0      (Y0),
        .CELL         (CELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .R          (R),
        .G          (G),
        .B          (B),
        .GridA_out  (GridA_out),
        .GridB_out  (GridB_out),
        .frame_valid(frame_valid),
        .decode_err (decode_err),
        .frame_short(frame_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] ga;
        logic [199:0] gb;
        bit           inj;
        logic [199:0] exp_a;
        logic [199:0] exp_b;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int fs_cnt = 0;

    logic [199:0] cur_ga, cur_gb;
    bit           cur_inj;

    // Pulse widths are counted cycle by cycle, so a stretched pulse shows as an extra count.
    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_cnt++;
        if (frame_short) fs_cnt++;
    end

    task automatic chk_vec(input string name, input logic [199:0] act, input logic [199:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] colour(input int ln, input int p);
        int  r, c, bi;
        logic a, bb;
        colour = 8'h00;
        if (ln >= Y0 && ln < Y0 + 20 * CELL && p >= X0 && p < X0 + 10 * CELL) begin
            r  = (ln - Y0) / CELL;
            c  = (p - X0) / CELL;
            bi = 199 - (10 * r + c);
            a  = cur_ga[bi];
            bb = cur_gb[bi];
            if (cur_inj && r == 5 && c == 3) colour = 8'hFF;
            else if (a && !bb) colour = 8'b111_000_00;
            else if (!a && bb) colour = 8'b000_000_11;
            else if (a && bb)  colour = 8'b000_111_00;
        end
    endfunction

    task automatic drive_pix(input logic hs, input logic vs, input logic [7:0] rgb);
        @(negedge clk);
        Hsync = hs;
        Vsync = vs;
        {R, G, B} = rgb;
        repeat (CPP - 1) @(negedge clk);
    endtask

    task automatic send_line(input int ln, input bit vs_line);
        logic vs;
        drive_pix(1'b0, 1'b1, 8'h00);
        for (int p = 0; p < LPX; p++) begin
            vs = !(vs_line && p >= 5 && p < 15);
            drive_pix(1'b1, vs, vs_line ? 8'h00 : colour(ln, p));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_vec("rst_mid_grid_a", GridA_out, '0);
        chk_vec("rst_mid_grid_b", GridB_out, '0);
        chk_int("rst_mid_err", int'(decode_err), 0);
        chk_int("rst_mid_fv", int'(frame_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [199:0] ga, input logic [199:0] gb, input bit inj,
                              input int last_line, input int rst_line);
        cur_ga  = ga;
        cur_gb  = gb;
        cur_inj = inj;
        send_line(0, 1'b1);
        for (int ln = 1; ln <= last_line; ln++) begin
            if (ln == rst_line) do_reset();
            send_line(ln, 1'b0);
        end
    endtask

    logic [199:0] pat_p, pat_q, pat_r;
    int fv0, fs0;

    initial begin
        pat_p = {20{10'b1011001110}};
        pat_q = {25{8'hA5}};
        pat_r = {40{5'b01001}};

        vecs[0] = '{ga: '0, gb: '0, inj: 1'b0, exp_a: '0, exp_b: '0, exp_err: 1'b0};
        vecs[1] = '{ga: {1'b1, 199'd0}, gb: 200'd1, inj: 1'b0,
                    exp_a: {1'b1, 199'd0}, exp_b: 200'd1, exp_err: 1'b0};
        vecs[2] = '{ga: 200'd1 << 100, gb: 200'd1 << 100, inj: 1'b0,
                    exp_a: 200'd1 << 100, exp_b: 200'd1 << 100, exp_err: 1'b0};
        vecs[3] = '{ga: '1, gb: '0, inj: 1'b1,
                    exp_a: ~(200'd1 << 146), exp_b: '0, exp_err: 1'b1};
        vecs[4] = '{ga: '0, gb: '0, inj: 1'b0, exp_a: '0, exp_b: '0, exp_err: 1'b0};
        vecs[5] = '{ga: {20{10'h2A5}}, gb: {25{8'h3C}}, inj: 1'b0,
                    exp_a: {20{10'h2A5}}, exp_b: {25{8'h3C}}, exp_err: 1'b0};

        rst_n = 1'b0;
        Hsync = 1'b1;
        Vsync = 1'b1;
        {R, G, B} = 8'h00;
        cur_ga = '0;
        cur_gb = '0;
        cur_inj = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_vec("reset_grid_a", GridA_out, '0);
        chk_vec("reset_grid_b", GridB_out, '0);
        chk_int("reset_fv", int'(frame_valid), 0);
        chk_int("reset_err", int'(decode_err), 0);
        chk_int("reset_short", int'(frame_short), 0);
        rst_n = 1'b1;

        // Tail of a frame already in progress: no Vsync seen yet, nothing may publish.
        cur_ga = '1;
        for (int ln = 30; ln <= NLINES; ln++) send_line(ln, 1'b0);
        chk_int("leadin_no_fv", fv_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            fv0 = fv_cnt;
            fs0 = fs_cnt;
            send_frame(vecs[i].ga, vecs[i].gb, vecs[i].inj, NLINES, -1);
            chk_int($sformatf("v%0d_fv", i), fv_cnt - fv0, 1);
            chk_int($sformatf("v%0d_short", i), fs_cnt - fs0, 0);
            chk_vec($sformatf("v%0d_grid_a", i), GridA_out, vecs[i].exp_a);
            chk_vec($sformatf("v%0d_grid_b", i), GridB_out, vecs[i].exp_b);
            chk_int($sformatf("v%0d_err", i), int'(decode_err), int'(vecs[i].exp_err));
        end

        // Frame cut short after line 20, then a full frame.
        fv0 = fv_cnt;
        fs0 = fs_cnt;
        send_frame('1, '1, 1'b0, 20, -1);
        chk_int("short_no_fv", fv_cnt - fv0, 0);
        chk_vec("short_hold_a", GridA_out, vecs[5].exp_a);
        chk_vec("short_hold_b", GridB_out, vecs[5].exp_b);
        send_frame(pat_p, ~pat_p, 1'b0, NLINES, -1);
        chk_int("short_pulse", fs_cnt - fs0, 1);
        chk_int("after_short_fv", fv_cnt - fv0, 1);
        chk_vec("after_short_a", GridA_out, pat_p);
        chk_vec("after_short_b", GridB_out, ~pat_p);

        // Reset in the middle of a frame: remainder discarded, next full frame publishes.
        fv0 = fv_cnt;
        send_frame(pat_q, pat_r, 1'b0, NLINES, 10);
        chk_int("rst_frame_no_fv", fv_cnt - fv0, 0);
        chk_vec("rst_hold_a", GridA_out, '0);
        fv0 = fv_cnt;
        send_frame(pat_q, pat_r, 1'b0, NLINES, -1);
        chk_int("post_rst_fv", fv_cnt - fv0, 1);
        chk_vec("post_rst_a", GridA_out, pat_q);
        chk_vec("post_rst_b", GridB_out, pat_r);
        chk_int("post_rst_err", int'(decode_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
